// File: rtl/sprite_compositor.sv
// Composites player and monster sprites over the background with a transparent index,
// and reports per-frame player/monster overlap counts to the game FSM through a valid/ack handshake.
module sprite_compositor #(
    parameter int COLR_BITS  = 4,
    parameter int TRANSP_IDX = 0,
    parameter int HIT_THRESH = 8,
    parameter int CNTW       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame,
    input  logic                 de,
    input  logic [COLR_BITS-1:0] pl_pix,
    input  logic [11:0]          pl_colr,
    input  logic                 pl_drawing,
    input  logic [COLR_BITS-1:0] mon_pix,
    input  logic [11:0]          mon_colr,
    input  logic                 mon_drawing,
    input  logic [11:0]          bg_colr,
    output logic [3:0]           o_r,
    output logic [3:0]           o_g,
    output logic [3:0]           o_b,
    output logic                 o_de,
    output logic                 hit_valid,
    input  logic                 hit_ack,
    output logic [CNTW-1:0]      hit_count,
    output logic                 hit_overrun
);

    localparam logic [COLR_BITS-1:0] TRANSP  = COLR_BITS'(TRANSP_IDX);
    localparam logic [CNTW-1:0]      CNT_MAX = '1;
    localparam logic [31:0]          THRESH  = 32'(HIT_THRESH);

    typedef enum logic {COUNT, REPORT} state_t;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [11:0] select_colr(
        input logic        vis,
        input logic        pl_op,
        input logic        mon_op,
        input logic [11:0] plc,
        input logic [11:0] monc,
        input logic [11:0] bgc
    );
        if (!vis)        return 12'h000;
        else if (pl_op)  return plc;
        else if (mon_op) return monc;
        else             return bgc;
    endfunction

    // Stage 1: register every pixel-interface input
    logic                 frame_p1, de_p1, pl_drawing_p1, mon_drawing_p1;
    logic [COLR_BITS-1:0] pl_pix_p1, mon_pix_p1;
    logic [11:0]          pl_colr_p1, mon_colr_p1, bg_colr_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_p1       <= 1'b0;
            de_p1          <= 1'b0;
            pl_drawing_p1  <= 1'b0;
            mon_drawing_p1 <= 1'b0;
            pl_pix_p1      <= '0;
            mon_pix_p1     <= '0;
            pl_colr_p1     <= '0;
            mon_colr_p1    <= '0;
            bg_colr_p1     <= '0;
        end else begin
            frame_p1       <= frame;
            de_p1          <= de;
            pl_drawing_p1  <= pl_drawing;
            mon_drawing_p1 <= mon_drawing;
            pl_pix_p1      <= pl_pix;
            mon_pix_p1     <= mon_pix;
            pl_colr_p1     <= pl_colr;
            mon_colr_p1    <= mon_colr;
            bg_colr_p1     <= bg_colr;
        end
    end

    logic pl_op_p1, mon_op_p1, ovl_p1;

    assign pl_op_p1  = pl_drawing_p1 && (pl_pix_p1 != TRANSP);
    assign mon_op_p1 = mon_drawing_p1 && (mon_pix_p1 != TRANSP);
    assign ovl_p1    = de_p1 && pl_op_p1 && mon_op_p1;

    // Stage 2: priority select; colour is forced to black outside the active area
    logic [11:0] colr_p2;
    logic        de_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            colr_p2 <= '0;
            de_p2   <= 1'b0;
        end else begin
            colr_p2 <= select_colr(de_p1, pl_op_p1, mon_op_p1, pl_colr_p1, mon_colr_p1, bg_colr_p1);
            de_p2   <= de_p1;
        end
    end

    assign o_r  = colr_p2[11:8];
    assign o_g  = colr_p2[7:4];
    assign o_b  = colr_p2[3:0];
    assign o_de = de_p2;

    // The overlap on the frame-pulse pixel opens the new frame, so the closed total is the held count
    logic [CNTW-1:0] ovl_cnt;
    logic            qualify;

    assign qualify = frame_p1 && (32'(ovl_cnt) >= THRESH);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovl_cnt <= '0;
        end else if (frame_p1) begin
            ovl_cnt <= ovl_p1 ? CNTW'(1) : '0;
        end else if (ovl_p1) begin
            ovl_cnt <= sat_inc(ovl_cnt);
        end
    end

    state_t state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= COUNT;
            hit_valid   <= 1'b0;
            hit_count   <= '0;
            hit_overrun <= 1'b0;
        end else begin
            case (state)
                COUNT: begin
                    if (qualify) begin
                        hit_count <= ovl_cnt;
                        hit_valid <= 1'b1;
                        state     <= REPORT;
                    end
                end
                REPORT: begin
                    if (qualify && hit_ack) begin
                        hit_count <= ovl_cnt;
                    end else if (qualify) begin
                        hit_overrun <= 1'b1;
                    end else if (hit_ack) begin
                        hit_valid <= 1'b0;
                        state     <= COUNT;
                    end
                end
                default: state <= COUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench: two compositor configurations share one stimulus stream and are checked
// every cycle against a frame-level behavioural model, plus directed literal expectations.
module tb_sprite_compositor;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame, de, pl_drawing, mon_drawing, hit_ack;
    logic [3:0]  pl_pix, mon_pix;
    logic [11:0] pl_colr, mon_colr, bg_colr;

    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
    logic        de_a, de_b, hv_a, hv_b, ho_a, ho_b;
    logic [15:0] hc_a;
    logic [3:0]  hc_b;

    int n_cmp = 0;
    int n_err = 0;
    logic started = 1'b0;

    always #5 clk = ~clk;

    sprite_compositor dut_a (
        .clk(clk), .rst(rst), .frame(frame), .de(de),
        .pl_pix(pl_pix), .pl_colr(pl_colr), .pl_drawing(pl_drawing),
        .mon_pix(mon_pix), .mon_colr(mon_colr), .mon_drawing(mon_drawing),
        .bg_colr(bg_colr), .o_r(r_a), .o_g(g_a), .o_b(b_a), .o_de(de_a),
        .hit_valid(hv_a), .hit_ack(hit_ack), .hit_count(hc_a), .hit_overrun(ho_a)
    );

    sprite_compositor #(.HIT_THRESH(1), .CNTW(4)) dut_b (
        .clk(clk), .rst(rst), .frame(frame), .de(de),
        .pl_pix(pl_pix), .pl_colr(pl_colr), .pl_drawing(pl_drawing),
        .mon_pix(mon_pix), .mon_colr(mon_colr), .mon_drawing(mon_drawing),
        .bg_colr(bg_colr), .o_r(r_b), .o_g(g_b), .o_b(b_b), .o_de(de_b),
        .hit_valid(hv_b), .hit_ack(hit_ack), .hit_count(hc_b), .hit_overrun(ho_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        frame, de, pld, md;
        logic [3:0]  pp, mp;
        logic [11:0] pc, mc, bg;
    } px_t;

    function automatic int th(input int k);
        return (k == 0) ? 8 : 1;
    endfunction

    function automatic int maxc(input int k);
        return (k == 0) ? 65535 : 15;
    endfunction

    // Topmost opaque layer wins; nothing is shown outside the active area.
    function automatic logic [11:0] pick(input px_t p);
        if (!p.de) return 12'h000;
        if (p.pld && p.pp != 0) return p.pc;
        if (p.md && p.mp != 0) return p.mc;
        return p.bg;
    endfunction

    px_t         m_s1;
    logic [11:0] m_colr;
    logic        m_de;
    int          m_fcnt [2];
    logic        m_valid[2];
    logic        m_over [2];
    int          m_cnt  [2];

    always @(posedge clk) begin : model
        int ov;
        int total;
        if (rst) begin
            m_s1   <= '0;
            m_colr <= '0;
            m_de   <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_fcnt[k]  <= 0;
                m_valid[k] <= 1'b0;
                m_over[k]  <= 1'b0;
                m_cnt[k]   <= 0;
            end
        end else begin
            m_de   <= m_s1.de;
            m_colr <= pick(m_s1);
            ov = (m_s1.de && m_s1.pld && m_s1.pp != 0 && m_s1.md && m_s1.mp != 0) ? 1 : 0;
            for (int k = 0; k < 2; k++) begin
                total = (m_fcnt[k] > maxc(k)) ? maxc(k) : m_fcnt[k];
                if (m_s1.frame && total >= th(k)) begin
                    if (!m_valid[k]) begin
                        m_valid[k] <= 1'b1;
                        m_cnt[k]   <= total;
                    end else if (hit_ack) begin
                        m_cnt[k] <= total;
                    end else begin
                        m_over[k] <= 1'b1;
                    end
                end else if (m_valid[k] && hit_ack) begin
                    m_valid[k] <= 1'b0;
                end
                m_fcnt[k] <= m_s1.frame ? ov : m_fcnt[k] + ov;
            end
            m_s1.frame <= frame;
            m_s1.de    <= de;
            m_s1.pld   <= pl_drawing;
            m_s1.md    <= mon_drawing;
            m_s1.pp    <= pl_pix;
            m_s1.mp    <= mon_pix;
            m_s1.pc    <= pl_colr;
            m_s1.mc    <= mon_colr;
            m_s1.bg    <= bg_colr;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("a_de",   {31'b0, de_a}, {31'b0, m_de});
            chk("a_rgb",  {20'b0, r_a, g_a, b_a}, {20'b0, m_colr});
            chk("a_hv",   {31'b0, hv_a}, {31'b0, m_valid[0]});
            chk("a_hc",   {16'b0, hc_a}, m_cnt[0]);
            chk("a_ho",   {31'b0, ho_a}, {31'b0, m_over[0]});
            chk("b_de",   {31'b0, de_b}, {31'b0, m_de});
            chk("b_rgb",  {20'b0, r_b, g_b, b_b}, {20'b0, m_colr});
            chk("b_hv",   {31'b0, hv_b}, {31'b0, m_valid[1]});
            chk("b_hc",   {28'b0, hc_b}, m_cnt[1]);
            chk("b_ho",   {31'b0, ho_b}, {31'b0, m_over[1]});
        end
    end

    // ---------------- stimulus ----------------
    task automatic px(input logic f, input logic d, input logic pld, input logic [3:0] pp,
                      input logic md, input logic [3:0] mp, input logic ack);
        frame = f; de = d; pl_drawing = pld; pl_pix = pp;
        mon_drawing = md; mon_pix = mp; hit_ack = ack;
        @(negedge clk);
    endtask

    task automatic ovl(input int n);
        repeat (n) px(1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 4'd5, 1'b0);
    endtask

    task automatic idle(input logic ack);
        px(1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 4'd5, ack);
    endtask

    task automatic pulse();
        px(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        frame = 0; de = 0; pl_drawing = 0; mon_drawing = 0; hit_ack = 0;
        pl_pix = 0; mon_pix = 0; pl_colr = 0; mon_colr = 0; bg_colr = 0;
        @(negedge clk);
        started = 1'b1;

        // T1: reset with random inputs
        repeat (3) begin
            pl_colr = 12'($urandom); mon_colr = 12'($urandom); bg_colr = 12'($urandom);
            px(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
               1'($urandom), 4'($urandom), 1'($urandom));
        end
        chk("t1_de", {31'b0, de_a}, 32'd0);
        chk("t1_rgb", {20'b0, r_a, g_a, b_a}, 32'd0);
        chk("t1_hv", {31'b0, hv_a}, 32'd0);
        rst = 1'b0;
        repeat (6) px(1'b0, 1'($urandom), 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);

        // T2: priority
        pl_colr = 12'hFA0; mon_colr = 12'h0F0; bg_colr = 12'h00F;
        repeat (2) px(1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 4'd5, 1'b0);
        chk("t2_pl", {20'b0, r_a, g_a, b_a}, 32'h0FA0);
        repeat (2) px(1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 4'd5, 1'b0);
        chk("t2_mon", {20'b0, r_a, g_a, b_a}, 32'h00F0);
        repeat (2) px(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 4'd5, 1'b0);
        chk("t2_bg", {20'b0, r_a, g_a, b_a}, 32'h000F);

        // T3: threshold
        pulse(); ovl(7); pulse(); idle(0); idle(0);
        chk("t3_below", {31'b0, hv_a}, 32'd0);
        ovl(8); pulse(); idle(0); idle(0);
        chk("t3_hv", {31'b0, hv_a}, 32'd1);
        chk("t3_hc", {16'b0, hc_a}, 32'd8);

        // T4: handshake
        ovl(20); pulse(); idle(0); idle(0);
        chk("t4_hold_hc", {16'b0, hc_a}, 32'd8);
        chk("t4_overrun", {31'b0, ho_a}, 32'd1);
        ovl(12); pulse(); idle(1); idle(0);
        chk("t4_ack_hv", {31'b0, hv_a}, 32'd1);
        chk("t4_ack_hc", {16'b0, hc_a}, 32'd12);
        idle(1); idle(0);
        chk("t4_clear", {31'b0, hv_a}, 32'd0);

        // T5: pulse-cycle overlap belongs to the new frame; saturation
        px(1'b1, 1'b1, 1'b1, 4'd3, 1'b1, 4'd5, 1'b0);
        ovl(7); pulse(); idle(0); idle(0);
        chk("t5_pulse_hv", {31'b0, hv_a}, 32'd1);
        chk("t5_pulse_hc", {16'b0, hc_a}, 32'd8);
        ovl(20); pulse(); idle(1); idle(0);
        chk("t5_a_hc", {16'b0, hc_a}, 32'd20);
        chk("t5_sat", {28'b0, hc_b}, 32'd15);

        // T6: reset mid-frame
        idle(1); idle(0); pulse(); ovl(5);
        rst = 1'b1; idle(0); rst = 1'b0;
        ovl(4); pulse(); idle(0); idle(0);
        chk("t6_hv", {31'b0, hv_a}, 32'd0);
        chk("t6_ho", {31'b0, ho_a}, 32'd0);

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            pl_colr = 12'($urandom); mon_colr = 12'($urandom); bg_colr = 12'($urandom);
            px(($urandom_range(0, 29) == 0),
               ($urandom_range(0, 7) != 0),
               ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom),
               ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom),
               ($urandom_range(0, 7) == 0));
        end
        rst = 1'b0;
        idle(0); idle(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
